// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, refresh FSM states and default
// timing used by the init, writer, reader and refresh controllers.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_NOP          = 4'b0111,
        CMD_PRECHARGE    = 4'b0010,
        CMD_AUTO_REFRESH = 4'b0001,
        CMD_DESELECT     = 4'b1111
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        RF_IDLE,
        RF_PRE,
        RF_WAIT_RP,
        RF_REF,
        RF_WAIT_RFC
    } refresh_state_t;

    localparam int unsigned REFRESH_INTERVAL_DEF = 1000;
    localparam int unsigned T_RP_DEF             = 3;
    localparam int unsigned T_RFC_DEF            = 9;
    localparam int unsigned MAX_PENDING_DEF      = 8;
    localparam int unsigned URGENT_LEVEL_DEF     = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Refresh interval counter: advances only while enabled and emits a single
// tick on the cycle it wraps from INTERVAL-1 back to zero.
module refresh_tick_gen #(
    parameter int unsigned INTERVAL = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == LAST);

    always_comb begin
        // NOTE: assign the default before any condition so no path leaves cnt_d unassigned (otherwise a latch is inferred).
        cnt_d = cnt_q;
        if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_refresh_ctrl.sv
// Auto-refresh scheduler: accrues pending refreshes, arbitrates for the shared
// command bus and issues PRECHARGE ALL followed by a burst of AUTO REFRESH.
module sdram_refresh_ctrl
    import sdram_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
    parameter int unsigned T_RP             = T_RP_DEF,
    parameter int unsigned T_RFC            = T_RFC_DEF,
    parameter int unsigned MAX_PENDING      = MAX_PENDING_DEF,
    parameter int unsigned URGENT_LEVEL     = URGENT_LEVEL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        grant,
    output logic        refresh_req,
    output logic        refresh_busy,
    output logic        urgent,
    output logic        overflow,
    output logic        refresh_done,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [11:0] addr,
    output logic [1:0]  ba,
    output logic        cke
);

    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
    localparam int unsigned WAIT_W = $clog2(max_u(T_RP, T_RFC) + 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_URG  = PEND_W'(URGENT_LEVEL);
    // Wait counters count down to zero, so load one less than the NOP count.
    localparam logic [WAIT_W-1:0] RP_LOAD   = WAIT_W'((T_RP > 1) ? T_RP - 2 : 0);
    localparam logic [WAIT_W-1:0] RFC_LOAD  = WAIT_W'((T_RFC > 1) ? T_RFC - 2 : 0);

    refresh_state_t    state_q, state_d;
    sdram_cmd_t        cmd_q, cmd_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              a10_q, a10_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic              urgent_q, urgent_d;
    logic              overflow_q, overflow_d;
    logic              tick, issue, rfc_end;

    refresh_tick_gen #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable),
        .tick_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cmd_d   = CMD_NOP;
        a10_d   = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        rfc_end = 1'b0;
        unique case (state_q)
            RF_IDLE: begin
                cmd_d  = CMD_DESELECT;
                busy_d = 1'b0;
                if (req_q && grant) begin
                    state_d = RF_PRE;
                    cmd_d   = CMD_PRECHARGE;
                    a10_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RF_PRE: begin
                if (T_RP > 1) begin
                    state_d = RF_WAIT_RP;
                    wait_d  = RP_LOAD;
                end else begin
                    state_d = RF_REF;
                    cmd_d   = CMD_AUTO_REFRESH;
                end
            end
            RF_WAIT_RP: begin
                if (wait_q == '0) begin
                    state_d = RF_REF;
                    cmd_d   = CMD_AUTO_REFRESH;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            RF_REF: begin
                if (T_RFC > 1) begin
                    state_d = RF_WAIT_RFC;
                    wait_d  = RFC_LOAD;
                end else begin
                    rfc_end = 1'b1;
                end
            end
            RF_WAIT_RFC: begin
                if (wait_q == '0) begin
                    rfc_end = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = RF_IDLE;
                cmd_d   = CMD_DESELECT;
                busy_d  = 1'b0;
            end
        endcase

        // Catch up the backlog without re-precharging while the reader still yields.
        if (rfc_end) begin
            if (pending_q != '0 && grant) begin
                state_d = RF_REF;
                cmd_d   = CMD_AUTO_REFRESH;
            end else begin
                state_d = RF_IDLE;
                cmd_d   = CMD_DESELECT;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    assign issue = (cmd_d == CMD_AUTO_REFRESH) && (pending_q != '0);

    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (tick && !issue) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (issue && !tick) begin
            pending_d = pending_q - PEND_W'(1);
        end
        urgent_d = (pending_d >= PEND_URG);
        req_d    = enable && (pending_q != '0) && (state_d == RF_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RF_IDLE;
            cmd_q      <= CMD_DESELECT;
            wait_q     <= '0;
            pending_q  <= '0;
            a10_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            req_q      <= 1'b0;
            urgent_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            wait_q     <= wait_d;
            pending_q  <= pending_d;
            a10_q      <= a10_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            req_q      <= req_d;
            urgent_q   <= urgent_d;
            overflow_q <= overflow_d;
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign addr         = {1'b0, a10_q, 10'b0};
    assign ba           = 2'b00;
    assign cke          = 1'b1;
    assign refresh_req  = req_q;
    assign refresh_busy = busy_q;
    assign urgent       = urgent_q;
    assign overflow     = overflow_q;
    assign refresh_done = done_q;

endmodule

// File: tb/tb_sdram_refresh_ctrl.sv
// Directed bench for sdram_refresh_ctrl with a 20-cycle refresh interval;
// each scenario restarts from reset so edge numbers are counted from release.
module tb_sdram_refresh_ctrl;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_DES = 4'b1111;

    logic        clk = 1'b0;
    logic        reset, enable, grant;
    logic        refresh_req, refresh_busy, urgent, overflow, refresh_done;
    logic        cs_n, ras_n, cas_n, we_n, cke;
    logic [11:0] addr;
    logic [1:0]  ba;
    logic [3:0]  cmd;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int base = 0;
    int busy_n, pre_n, ar_n, bad;
    logic [3:0] exp_trace [13];

    assign cmd = {cs_n, ras_n, cas_n, we_n};

    sdram_refresh_ctrl #(
        .REFRESH_INTERVAL (20),
        .T_RP             (3),
        .T_RFC            (9),
        .MAX_PENDING      (8),
        .URGENT_LEVEL     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .grant        (grant),
        .refresh_req  (refresh_req),
        .refresh_busy (refresh_busy),
        .urgent       (urgent),
        .overflow     (overflow),
        .refresh_done (refresh_done),
        .cs_n         (cs_n),
        .ras_n        (ras_n),
        .cas_n        (cas_n),
        .we_n         (we_n),
        .addr         (addr),
        .ba           (ba),
        .cke          (cke)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait until the falling edge that follows rising edge k after release.
    task automatic at(input int k);
        while ((cyc - base) < k) @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        grant  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_rst(input logic en, input logic gr);
        reset  = 1'b0;
        enable = en;
        grant  = gr;
        base   = cyc;
    endtask

    // Called on the sample showing PRECHARGE; ends on the sample after busy drops.
    task automatic measure(output int b, output int p, output int a);
        int guard;
        guard = 0;
        b = 0;
        p = 0;
        a = 0;
        while (refresh_busy && guard < 400) begin
            b++;
            if (cmd == C_PRE) p++;
            if (cmd == C_REF) a++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 400) check("tenure_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_trace[0] = C_PRE;
        exp_trace[1] = C_NOP;
        exp_trace[2] = C_NOP;
        exp_trace[3] = C_REF;
        for (int i = 4; i < 12; i++) exp_trace[i] = C_NOP;
        exp_trace[12] = C_DES;

        reset  = 1'b1;
        enable = 1'b0;
        grant  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd", cmd, C_DES);
        check("rst_addr", addr, 0);
        check("rst_ba", ba, 0);
        check("rst_cke", cke, 1);
        check("rst_req", refresh_req, 0);
        check("rst_busy", refresh_busy, 0);
        check("rst_urgent", urgent, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", refresh_done, 0);

        // Single refresh: full command trace with grant held.
        release_rst(1'b1, 1'b0);
        at(20); check("a_req_pre_tick", refresh_req, 0);
        at(21); check("a_req_post_tick", refresh_req, 1);
        grant = 1'b1;
        for (int i = 0; i < 13; i++) begin
            at(22 + i);
            check($sformatf("a_cmd%0d", i), cmd, exp_trace[i]);
            check($sformatf("a_busy%0d", i), refresh_busy, (i < 12) ? 1 : 0);
            check($sformatf("a_addr%0d", i), addr, (i == 0) ? 12'h400 : 12'h000);
        end
        check("a_done", refresh_done, 1);
        check("a_req_end", refresh_req, 0);
        grant = 1'b0;
        at(35); check("a_done_pulse", refresh_done, 0);
        check("a_pend_zero", refresh_req, 0);
        at(40); check("a_req_e40", refresh_req, 0);
        at(41); check("a_req_e41", refresh_req, 1);

        // Backlog of five, urgent at four, then one burst with enable dropped.
        do_reset();
        release_rst(1'b1, 1'b0);
        at(21); check("b_req", refresh_req, 1);
        at(79); check("b_urgent_p3", urgent, 0);
        at(80); check("b_urgent_p4", urgent, 1);
        at(101); check("b_req_p5", refresh_req, 1);
        grant  = 1'b1;
        enable = 1'b0;
        at(102); check("b_pre", cmd, C_PRE);
        measure(busy_n, pre_n, ar_n);
        check("b_busy_len", busy_n, 48);
        check("b_pre_cnt", pre_n, 1);
        check("b_ar_cnt", ar_n, 5);
        check("b_done", refresh_done, 1);
        check("b_req_end", refresh_req, 0);
        check("b_urgent_end", urgent, 0);
        check("b_overflow", overflow, 0);

        // Tick coincides with the second AUTO REFRESH; grant drops mid-burst.
        do_reset();
        release_rst(1'b1, 1'b0);
        at(47); check("c_req", refresh_req, 1);
        grant = 1'b1;
        at(48); check("c_pre", cmd, C_PRE);
        at(51); check("c_ar1", cmd, C_REF);
        at(60); check("c_ar2", cmd, C_REF);
        at(61); grant = 1'b0;
        at(68); check("c_busy_e68", refresh_busy, 1);
        at(69); check("c_busy_e69", refresh_busy, 0);
        check("c_done", refresh_done, 1);
        check("c_req_again", refresh_req, 1);
        enable = 1'b0;
        grant  = 1'b1;
        at(70); check("c_pre2", cmd, C_PRE);
        measure(busy_n, pre_n, ar_n);
        check("c_ar_left", ar_n, 1);
        check("c_busy_len", busy_n, 12);

        // Reset in the middle of WAIT_RFC with one refresh still pending.
        do_reset();
        release_rst(1'b1, 1'b0);
        at(41); grant = 1'b1;
        at(42); check("d_pre", cmd, C_PRE);
        at(48); check("d_mid_rfc", cmd, C_NOP);
        reset = 1'b1;
        #1;
        check("d_async_cs_n", cs_n, 1);
        check("d_async_busy", refresh_busy, 0);
        @(negedge clk);
        check("d_rst_cs_n", cs_n, 1);
        check("d_rst_busy", refresh_busy, 0);
        check("d_rst_req", refresh_req, 0);
        check("d_rst_done", refresh_done, 0);
        release_rst(1'b1, 1'b1);
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            at(k);
            if (refresh_busy || refresh_req) bad++;
        end
        check("d_quiet_20", bad, 0);
        at(21); check("d_req_tick", refresh_req, 1);
        at(22); check("d_pre2", cmd, C_PRE);

        // Saturation at eight and sticky overflow.
        do_reset();
        release_rst(1'b1, 1'b0);
        at(160); check("e_urgent", urgent, 1);
        at(179); check("e_ovf_before", overflow, 0);
        at(180); check("e_ovf_set", overflow, 1);
        at(181);
        grant  = 1'b1;
        enable = 1'b0;
        at(182); check("e_pre", cmd, C_PRE);
        measure(busy_n, pre_n, ar_n);
        check("e_ar_cnt", ar_n, 8);
        check("e_busy_len", busy_n, 75);
        check("e_done", refresh_done, 1);
        check("e_ovf_sticky", overflow, 1);
        check("e_req_end", refresh_req, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
